pos_cache_reader: RTL

- Downstream read controller for one cell's position cache. It drives the cache's read address and read enable.
- On start, it reads the particle count at address 0, then streams particles 1..N to the force-evaluation filter.
- Output is a valid/ready stream with a 2-entry skid buffer, which absorbs the cache's 1-cycle read latency under backpressure.
- One instance per cell in the RL_LJ top level, between the position cache and the pair filter.

---
 rtl/md_rl_pkg.sv | 21 ++
 rtl/pos_skid_buffer_2.sv | 90 +++++++++
 rtl/pos_cache_reader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/md_rl_pkg.sv
// Shared definitions for the RL_LJ position-cache readers: FSM states and particle word geometry.
// MD_RL_PARTICLE_W gives the width of one {posz, posy, posx} word.
`ifndef MD_RL_PARTICLE_W
`define MD_RL_PARTICLE_W(dw) (3*(dw))
`endif

package md_rl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ_NUM  = 3'd1,
        ST_LATCH_NUM = 3'd2,
        ST_STREAM    = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } rd_state_e;

    // The particle count lives at this cache address; particles follow from COUNT_ADDR + 1.
    localparam int unsigned COUNT_ADDR = 0;

endpackage

// File: rtl/pos_skid_buffer_2.sv
// Two-entry valid/ready buffer holding {addr, data}; an arriving word falls straight through
// when the buffer is empty, so an unstalled stream sustains one word per cycle.
module pos_skid_buffer_2 #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 96
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    input  logic          in_ready,
    output logic [1:0]    occupancy
);

    logic [1:0]    occ_r;
    logic [AW-1:0] addr0_r, addr1_r;
    logic [DW-1:0] data0_r, data1_r;
    logic          fire_s;

    assign out_valid = (occ_r != 2'd0) | in_valid;
    assign fire_s    = out_valid & in_ready;
    assign occupancy = occ_r;

    // Head selection: oldest stored entry first, otherwise the word arriving this cycle
    always_comb begin
        out_addr = {AW{1'b0}};
        out_data = {DW{1'b0}};
        if (occ_r != 2'd0) begin
            out_addr = addr0_r;
            out_data = data0_r;
        end else if (in_valid) begin
            out_addr = in_addr;
            out_data = in_data;
        end else begin
            out_addr = {AW{1'b0}};
            out_data = {DW{1'b0}};
        end
    end

    // Storage update; the reader's issue rule guarantees a push never meets a full, stalled buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r   <= 2'd0;
            addr0_r <= {AW{1'b0}};
            addr1_r <= {AW{1'b0}};
            data0_r <= {DW{1'b0}};
            data1_r <= {DW{1'b0}};
        end else begin
            case (occ_r)
                2'd0: begin
                    if (in_valid && !fire_s) begin
                        addr0_r <= in_addr;
                        data0_r <= in_data;
                        occ_r   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (fire_s && in_valid) begin
                        addr0_r <= in_addr;
                        data0_r <= in_data;
                    end else if (fire_s) begin
                        occ_r <= 2'd0;
                    end else if (in_valid) begin
                        addr1_r <= in_addr;
                        data1_r <= in_data;
                        occ_r   <= 2'd2;
                    end
                end
                2'd2: begin
                    if (fire_s) begin
                        addr0_r <= addr1_r;
                        data0_r <= data1_r;
                        if (in_valid) begin
                            addr1_r <= in_addr;
                            data1_r <= in_data;
                        end else begin
                            occ_r <= 2'd1;
                        end
                    end
                end
                default: occ_r <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/pos_cache_reader.sv
// Reads the particle count at cache address 0, then streams particles 1..N through a 2-entry skid.
// Defining POS_CACHE_READER_CELL_TAG_EN adds the out_cell_id and out_last stream sidebands.
module pos_cache_reader
    import md_rl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned PARTICLE_NUM  = 220,
    parameter int unsigned CELL_ID_WIDTH = 4,
    parameter int unsigned CELL_X        = 0,
    parameter int unsigned CELL_Y        = 0,
    parameter int unsigned CELL_Z        = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    output logic [ADDR_WIDTH-1:0]                    out_read_address,
    output logic                                     out_rden,
    input  logic [`MD_RL_PARTICLE_W(DATA_WIDTH)-1:0] in_particle_info,
    output logic [`MD_RL_PARTICLE_W(DATA_WIDTH)-1:0] out_particle_data,
    output logic [ADDR_WIDTH-1:0]                    out_particle_addr,
    output logic                                     out_valid,
    input  logic                                     in_ready,
    output logic [ADDR_WIDTH-1:0]                    out_particle_count,
    output logic                                     busy,
    output logic                                     done
`ifdef POS_CACHE_READER_CELL_TAG_EN
    ,
    output logic [3*CELL_ID_WIDTH-1:0]               out_cell_id,
    output logic                                     out_last
`endif
);

    localparam int unsigned PW = `MD_RL_PARTICLE_W(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = ADDR_WIDTH'(PARTICLE_NUM);

    rd_state_e             state_r, state_s;
    logic [ADDR_WIDTH-1:0] count_r, next_addr_r, last_addr_r, clamped_s;
    logic                  arrive_r, issue_s, fire_s, drain_empty_s;
    logic [1:0]            occ_s;

    // A stream read may issue only if its return is guaranteed a free slot
    assign issue_s = (state_r == ST_STREAM) && (({1'b0, occ_s} + {2'b00, arrive_r}) < 3'd2);
    assign fire_s  = out_valid & in_ready;
    assign drain_empty_s = (({1'b0, occ_s} + {2'b00, arrive_r}) == {2'b00, fire_s});

    assign out_rden           = (state_r == ST_READ_NUM) | issue_s;
    assign out_read_address   = issue_s ? next_addr_r : last_addr_r;
    assign out_particle_count = count_r;
    assign busy               = (state_r != ST_IDLE) && (state_r != ST_DONE);
    assign done               = (state_r == ST_DONE);

    // Count clamp: anything above PARTICLE_NUM streams PARTICLE_NUM words
    always_comb begin
        clamped_s = in_particle_info[ADDR_WIDTH-1:0];
        if (in_particle_info[ADDR_WIDTH-1:0] > COUNT_MAX) begin
            clamped_s = COUNT_MAX;
        end else begin
            clamped_s = in_particle_info[ADDR_WIDTH-1:0];
        end
    end

    // Next-state logic for the read pass
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_READ_NUM;
                else       state_s = ST_IDLE;
            end
            ST_READ_NUM:  state_s = ST_LATCH_NUM;
            ST_LATCH_NUM: begin
                if (clamped_s == {ADDR_WIDTH{1'b0}}) state_s = ST_DONE;
                else                                 state_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (issue_s && (next_addr_r == count_r)) state_s = ST_DRAIN;
                else                                     state_s = ST_STREAM;
            end
            ST_DRAIN: begin
                if (drain_empty_s) state_s = ST_DONE;
                else               state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, latched count and read-address bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            count_r     <= {ADDR_WIDTH{1'b0}};
            next_addr_r <= {ADDR_WIDTH{1'b0}};
            last_addr_r <= {ADDR_WIDTH{1'b0}};
            arrive_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            arrive_r <= issue_s;
            if (state_r == ST_LATCH_NUM) begin
                count_r <= clamped_s;
            end
            if ((state_r == ST_IDLE) && start) begin
                last_addr_r <= ADDR_WIDTH'(COUNT_ADDR);
                next_addr_r <= ADDR_WIDTH'(COUNT_ADDR + 1);
            end else if (issue_s) begin
                last_addr_r <= next_addr_r;
                next_addr_r <= next_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    pos_skid_buffer_2 #(
        .AW (ADDR_WIDTH),
        .DW (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (arrive_r),
        .in_addr   (last_addr_r),
        .in_data   (in_particle_info),
        .out_valid (out_valid),
        .out_addr  (out_particle_addr),
        .out_data  (out_particle_data),
        .in_ready  (in_ready),
        .occupancy (occ_s)
    );

`ifdef POS_CACHE_READER_CELL_TAG_EN
    assign out_cell_id = out_valid ? {CELL_ID_WIDTH'(CELL_X), CELL_ID_WIDTH'(CELL_Y), CELL_ID_WIDTH'(CELL_Z)}
                                   : {(3*CELL_ID_WIDTH){1'b0}};
    assign out_last    = out_valid && (out_particle_addr == count_r);
`endif

endmodule
